// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI4-Lite bridge: FSM encoding and source tags.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4
    } state_t;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

endpackage

// File: rtl/sram_axi_bridge_wr_ctrl.sv
// AW/W channel sequencing for one AXI4-Lite write: both valids rise together and
// each drops independently after its own handshake.
module sram_axi_bridge_wr_ctrl (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic aw_done;
    logic w_done;

    assign awvalid = active && !aw_done;
    assign wvalid  = active && !w_done;

    // Counts a handshake happening this very cycle, so B follows the last one directly.
    assign both_done = active
                    && (aw_done || awready)
                    && (w_done  || wready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!active) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates an instruction and a data SRAM-like port onto a single AXI4-Lite master,
// one transaction in flight, responses returned to the originating port.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter bit          DATA_FIRST = 1'b1,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_t            state, state_nxt;
    logic              grant_inst, grant_data;
    logic              wr_both_done;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              src_q;

    // Grants are gated by resetn so no addr_ok can escape while reset is held.
    always_comb begin
        state_nxt  = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state)
            ST_IDLE: begin
                if (resetn) begin
                    if (data_req && (DATA_FIRST || !inst_req)) grant_data = 1'b1;
                    else if (inst_req)                         grant_inst = 1'b1;
                end
                if (grant_data)      state_nxt = data_wr ? ST_WR : ST_AR;
                else if (grant_inst) state_nxt = ST_AR;
            end
            ST_AR:   if (arready)      state_nxt = ST_R;
            ST_R:    if (rvalid)       state_nxt = ST_IDLE;
            ST_WR:   if (wr_both_done) state_nxt = ST_B;
            ST_B:    if (bvalid)       state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            src_q        <= SRC_INST;
            inst_rdata   <= '0;
            data_rdata   <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            if (grant_data) begin
                addr_q  <= data_addr;
                wdata_q <= data_wdata;
                wstrb_q <= data_wr ? data_wstrb : 4'h0;
                src_q   <= SRC_DATA;
            end else if (grant_inst) begin
                addr_q  <= inst_addr;
                wdata_q <= '0;
                wstrb_q <= 4'h0;
                src_q   <= SRC_INST;
            end
            if (state == ST_R && rvalid) begin
                if (src_q == SRC_INST) begin
                    inst_rdata   <= rdata;
                    inst_data_ok <= 1'b1;
                end else begin
                    data_rdata   <= rdata;
                    data_data_ok <= 1'b1;
                end
            end
            if (state == ST_B && bvalid) data_data_ok <= 1'b1;
        end
    end

    sram_axi_bridge_wr_ctrl u_wr_ctrl (
        .clk       (clk),
        .resetn    (resetn),
        .active    (state == ST_WR),
        .awready   (awready),
        .wready    (wready),
        .awvalid   (awvalid),
        .wvalid    (wvalid),
        .both_done (wr_both_done)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign araddr       = addr_q;
    assign awaddr       = addr_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign arvalid      = (state == ST_AR);
    assign rready       = (state == ST_R);
    assign bready       = (state == ST_B);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: transaction-level reference model, per-cycle compare,
// and hand-computed cycle/data expectations for each scenario.
module tb_sram_axi_bridge;

    localparam bit DATA_FIRST = 1'b1;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_bridge #(.DATA_FIRST(DATA_FIRST), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event want event within bound", name);
    endtask

    // Reference model: the in-flight transaction is a set of outstanding AXI obligations.
    logic        m_need_ar = 0, m_need_r = 0, m_need_aw = 0, m_need_w = 0, m_need_b = 0;
    logic        m_src = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_wstrb = 0;
    logic [31:0] m_inst_rdata = 0, m_data_rdata = 0;
    logic        m_inst_dok = 0, m_data_dok = 0;
    logic        m_busy, e_aok_i, e_aok_d;
    logic        e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready;

    assign m_busy    = m_need_ar | m_need_r | m_need_aw | m_need_w | m_need_b;
    assign e_aok_d   = resetn && !m_busy && data_req && (DATA_FIRST || !inst_req);
    assign e_aok_i   = resetn && !m_busy && inst_req && !(DATA_FIRST && data_req);
    assign e_arvalid = m_need_ar;
    assign e_rready  = !m_need_ar && m_need_r;
    assign e_awvalid = m_need_aw;
    assign e_wvalid  = m_need_w;
    assign e_bready  = !m_need_aw && !m_need_w && m_need_b;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_need_ar <= 0; m_need_r <= 0; m_need_aw <= 0; m_need_w <= 0; m_need_b <= 0;
            m_src <= 0; m_addr <= 0; m_wdata <= 0; m_wstrb <= 0;
            m_inst_rdata <= 0; m_data_rdata <= 0; m_inst_dok <= 0; m_data_dok <= 0;
        end else begin
            m_inst_dok <= e_rready && rvalid && !m_src;
            m_data_dok <= (e_rready && rvalid && m_src) || (e_bready && bvalid);
            if (e_rready && rvalid) begin
                if (m_src) m_data_rdata <= rdata;
                else       m_inst_rdata <= rdata;
            end
            if (e_arvalid && arready) m_need_ar <= 0;
            if (e_rready && rvalid)   m_need_r  <= 0;
            if (e_awvalid && awready) m_need_aw <= 0;
            if (e_wvalid && wready)   m_need_w  <= 0;
            if (e_bready && bvalid)   m_need_b  <= 0;
            if (e_aok_d) begin
                m_src <= 1; m_addr <= data_addr; m_wdata <= data_wdata; m_wstrb <= data_wstrb;
                m_need_ar <= !data_wr; m_need_r <= !data_wr;
                m_need_aw <= data_wr; m_need_w <= data_wr; m_need_b <= data_wr;
            end else if (e_aok_i) begin
                m_src <= 0; m_addr <= inst_addr; m_need_ar <= 1; m_need_r <= 1;
            end
        end
    end

    always @(negedge clk) begin
        check1("inst_addr_ok", inst_addr_ok, e_aok_i);
        check1("data_addr_ok", data_addr_ok, e_aok_d);
        check1("inst_data_ok", inst_data_ok, m_inst_dok);
        check1("data_data_ok", data_data_ok, m_data_dok);
        check32("inst_rdata", inst_rdata, m_inst_rdata);
        check32("data_rdata", data_rdata, m_data_rdata);
        check1("arvalid", arvalid, e_arvalid);
        check1("rready", rready, e_rready);
        check1("awvalid", awvalid, e_awvalid);
        check1("wvalid", wvalid, e_wvalid);
        check1("bready", bready, e_bready);
        if (e_arvalid || !resetn) check32("araddr", araddr, m_addr);
        if (e_awvalid || !resetn) check32("awaddr", awaddr, m_addr);
        if (e_wvalid || !resetn) begin
            check32("wdata", wdata, m_wdata);
            check32("wstrb", {28'h0, wstrb}, {28'h0, m_wstrb});
        end
    end

    // Event log for the hand-computed timing checks.
    int aok_i_cyc = 0, aok_d_cyc = 0, dok_i_cyc = 0, dok_d_cyc = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, b_cyc = 0;
    int n_inst_dok = 0, n_data_dok = 0;
    logic [3:0] w_hs_strb = 0;

    always @(negedge clk) begin
        if (inst_addr_ok) aok_i_cyc <= cyc;
        if (data_addr_ok) aok_d_cyc <= cyc;
        if (inst_data_ok) begin dok_i_cyc <= cyc; n_inst_dok <= n_inst_dok + 1; end
        if (data_data_ok) begin dok_d_cyc <= cyc; n_data_dok <= n_data_dok + 1; end
        if (awvalid && awready) aw_hs_cyc <= cyc;
        if (wvalid && wready) begin w_hs_cyc <= cyc; w_hs_strb <= wstrb; end
        if (bready) b_cyc <= cyc;
    end

    // AXI slave with per-channel programmable ready delays.
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
    logic [31:0] rd_val = 0;

    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(posedge clk);
            #1;
            arready = arvalid && (ar_cnt >= ar_delay);
            ar_cnt  = arvalid ? ar_cnt + 1 : 0;
            rvalid  = rready && (r_cnt >= r_delay);
            rdata   = rvalid ? rd_val : 32'h0;
            r_cnt   = rready ? r_cnt + 1 : 0;
            awready = awvalid && (aw_cnt >= aw_delay);
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid && (w_cnt >= w_delay);
            w_cnt   = wvalid ? w_cnt + 1 : 0;
            bvalid  = bready;
        end
    end

    task automatic issue(input bit ie, input logic [31:0] ia, input bit de, input bit dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dws,
                         input bit wait_resp);
        int ni0, nd0;
        bit done, a_i, a_d;
        ni0 = n_inst_dok; nd0 = n_data_dok; done = 0;
        inst_req = ie; inst_addr = ia;
        data_req = de; data_wr = dw; data_addr = da; data_wdata = dwd; data_wstrb = dws;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            a_i = inst_addr_ok;
            a_d = data_addr_ok;
            @(posedge clk);
            #1;
            if (a_i) inst_req = 0;
            if (a_d) data_req = 0;
            if (!inst_req && !data_req &&
                (!wait_resp || ((n_inst_dok - ni0) >= int'(ie) && (n_data_dok - nd0) >= int'(de)))) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            timeout_fail("issue");
            inst_req = 0;
            data_req = 0;
        end
    endtask

    initial begin
        int n0;
        bit seen;
        resetn = 0;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        inst_req = 1;
        data_req = 1;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        check1("rst_data_addr_ok", data_addr_ok, 1'b0);
        check1("rst_arvalid", arvalid, 1'b0);
        check32("rst_araddr", araddr, 32'h0);
        inst_req = 0;
        data_req = 0;
        @(posedge clk);
        #1;
        resetn = 1;
        repeat (2) @(posedge clk);
        #1;

        // Single instruction read, zero-wait AXI.
        rd_val = 32'h3C080001;
        issue(1, 32'hBFC00000, 0, 0, 0, 0, 0, 1);
        check32("t1_latency", dok_i_cyc - aok_i_cyc, 3);
        check32("t1_inst_rdata", inst_rdata, 32'h3C080001);

        // Simultaneous requests: data wins, instruction accepted once the bridge is free.
        rd_val = 32'h11223344;
        issue(1, 32'hBFC00004, 1, 0, 32'h80001000, 0, 0, 1);
        check1("t2_data_first", aok_d_cyc < aok_i_cyc, 1'b1);
        check32("t2_inst_after_dok", aok_i_cyc - dok_d_cyc, 0);
        check32("t2_data_rdata", data_rdata, 32'h11223344);
        check32("t2_data_latency", dok_d_cyc - aok_d_cyc, 3);

        // Write with independent AW/W acceptance.
        aw_delay = 0; w_delay = 3;
        issue(0, 0, 1, 1, 32'h80000010, 32'hDEADBEEF, 4'h3, 1);
        check32("t3_aw_hs", aw_hs_cyc - aok_d_cyc, 1);
        check32("t3_w_hs", w_hs_cyc - aok_d_cyc, 4);
        check32("t3_wstrb", {28'h0, w_hs_strb}, 32'h3);
        check32("t3_b_cycle", b_cyc - aok_d_cyc, 5);
        check32("t3_dok", dok_d_cyc - aok_d_cyc, 6);
        w_delay = 0;

        // AR stall of 10 cycles with the instruction port held waiting.
        ar_delay = 10; rd_val = 32'h0000A5A5;
        issue(1, 32'hBFC00008, 1, 0, 32'h80002000, 0, 0, 1);
        check32("t4_data_latency", dok_d_cyc - aok_d_cyc, 13);
        check32("t4_inst_latency", dok_i_cyc - aok_i_cyc, 13);
        check32("t4_inst_after_dok", aok_i_cyc - dok_d_cyc, 0);
        check32("t4_inst_rdata", inst_rdata, 32'h0000A5A5);
        ar_delay = 0;

        // Reset while waiting in R.
        r_delay = 5; rd_val = 32'hCAFE0001;
        issue(1, 32'hBFC00100, 0, 0, 0, 0, 0, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rready) begin seen = 1; break; end
        end
        if (!seen) timeout_fail("t5_reach_r");
        #2;
        n0 = n_inst_dok;
        resetn = 0;
        #1;
        check1("t5_rready", rready, 1'b0);
        check1("t5_arvalid", arvalid, 1'b0);
        check1("t5_inst_data_ok", inst_data_ok, 1'b0);
        check32("t5_inst_rdata", inst_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1;
        repeat (8) @(posedge clk);
        #1;
        check32("t5_no_dok", n_inst_dok - n0, 0);
        r_delay = 0; rd_val = 32'h24020005;
        issue(1, 32'hBFC00000, 0, 0, 0, 0, 0, 1);
        check32("t5_fresh_latency", dok_i_cyc - aok_i_cyc, 3);
        check32("t5_fresh_rdata", inst_rdata, 32'h24020005);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
